// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared opcodes, state encoding and widths for mcu_core_param
// Contents: opcode width, opcode localparams OP_NOP..OP_HLT, FSM state enum.
package mcu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'd2;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'd4;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'd5;
    localparam logic [OPC_W-1:0] OP_JNZ  = 4'd6;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'd7;
    localparam logic [OPC_W-1:0] OP_IN   = 4'd8;
    localparam logic [OPC_W-1:0] OP_JC   = 4'd9;
    localparam logic [OPC_W-1:0] OP_MOVA = 4'd10;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/mcu_prog_mem.sv
// rtl/mcu_prog_mem.sv - program RAM with synchronous write and registered read
// Ports:
//   clk_i, rst_n_i        clock, async active-low reset (read register only)
//   we_i, wr_addr_i/data  write port, takes effect at the clock edge
//   rd_en_i, rd_addr_i    read request; data appears on rd_data_o next cycle
//   rd_data_o             registered read data (serves as the core's IR)
module mcu_prog_mem #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rd_data_q;

    // Array contents are deliberately not reset so the array maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mcu_core_param.sv
// rtl/mcu_core_param.sv - parametrised accumulator core with loadable program memory
// Ports:
//   clk_i, rst_n_i                          clock, async active-low reset
//   run_i                                   start request (IDLE), restart gate (HALT)
//   prog_we_i, prog_addr_i, prog_data_i     program load port, honoured in IDLE/HALT
//   data_in_i, data_in_valid_i/ready_o      IN instruction handshake
//   data_out_o, data_out_valid_o            OUT result and one-cycle strobe
//   busy_o, halted_o, pc_o                  status
module mcu_core_param
    import mcu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    run_i,
    input  logic                    prog_we_i,
    input  logic [ADDR_W-1:0]       prog_addr_i,
    input  logic [OPC_W+DATA_W-1:0] prog_data_i,
    input  logic [DATA_W-1:0]       data_in_i,
    input  logic                    data_in_valid_i,
    output logic                    data_in_ready_o,
    output logic [DATA_W-1:0]       data_out_o,
    output logic                    data_out_valid_o,
    output logic                    busy_o,
    output logic                    halted_o,
    output logic [ADDR_W-1:0]       pc_o
);

    localparam int WORD_W = OPC_W + DATA_W;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               z_q, z_d;
    logic               c_q, c_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               in_ready;

    logic [WORD_W-1:0]  ir;
    logic [OPC_W-1:0]   opcode;
    logic [DATA_W-1:0]  imm;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  jmp_tgt;
    logic [DATA_W:0]    add_res;
    logic [DATA_W:0]    sub_res;
    logic               mem_we;

    // Loads are only accepted while the core is not executing, so a fetch
    // can never collide with a write to the same word.
    assign mem_we = prog_we_i && ((state_q == ST_IDLE) || (state_q == ST_HALT));

    mcu_prog_mem #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_prog_mem (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .we_i      (mem_we),
        .wr_addr_i (prog_addr_i),
        .wr_data_i (prog_data_i),
        .rd_en_i   (state_q == ST_FETCH),
        .rd_addr_i (pc_q),
        .rd_data_o (ir)
    );

    assign opcode  = ir[WORD_W-1 -: OPC_W];
    assign imm     = ir[DATA_W-1:0];
    assign pc_inc  = pc_q + ADDR_W'(1);
    assign jmp_tgt = ADDR_W'(imm);

    // Extra top bit carries out of ADD and holds the borrow of SUB.
    assign add_res = {1'b0, acc_q} + {1'b0, a_q};
    assign sub_res = {1'b0, acc_q} - {1'b0, a_q};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        a_d          = a_q;
        acc_d        = acc_q;
        z_d          = z_q;
        c_d          = c_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        in_ready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_LDI: a_d = imm;
                    OP_ADD: begin
                        acc_d = add_res[DATA_W-1:0];
                        c_d   = add_res[DATA_W];
                        z_d   = (add_res[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        acc_d = sub_res[DATA_W-1:0];
                        c_d   = sub_res[DATA_W];
                        z_d   = (sub_res[DATA_W-1:0] == '0);
                    end
                    OP_JMP: pc_d = jmp_tgt;
                    OP_JZ: begin
                        if (z_q) pc_d = jmp_tgt;
                    end
                    OP_JNZ: begin
                        if (!z_q) pc_d = jmp_tgt;
                    end
                    OP_JC: begin
                        if (c_q) pc_d = jmp_tgt;
                    end
                    OP_OUT: begin
                        dout_d       = acc_q;
                        dout_valid_d = 1'b1;
                    end
                    OP_IN: begin
                        // Hold in EXEC with PC frozen until the producer is valid.
                        in_ready = 1'b1;
                        if (data_in_valid_i) begin
                            a_d = data_in_i;
                        end else begin
                            state_d = ST_EXEC;
                            pc_d    = pc_q;
                        end
                    end
                    OP_MOVA: begin
                        acc_d = a_q;
                        z_d   = (a_q == '0);
                    end
                    OP_HLT: begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end

            ST_HALT: begin
                // Requires RUN_I to drop before a new run can start.
                if (!run_i) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            a_q          <= '0;
            acc_q        <= '0;
            z_q          <= 1'b0;
            c_q          <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            a_q          <= a_d;
            acc_q        <= acc_d;
            z_q          <= z_d;
            c_q          <= c_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign data_in_ready_o  = in_ready;
    assign data_out_o       = dout_q;
    assign data_out_valid_o = dout_valid_q;
    assign busy_o           = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted_o         = (state_q == ST_HALT);
    assign pc_o             = pc_q;

endmodule

// File: doc/mcu_core_param.md
# mcu_core_param

Parametrised accumulator microcontroller core with an internal, externally loadable program memory, a fetch/execute state machine, carry/zero flags and handshaked data input/output ports. It is the next-generation controller for the FPGA examples set. Programs are loaded while the core is idle. The core then runs autonomously from address 0 until it executes HLT, and exchanges data with surrounding logic through valid/ready style ports.

## Interface
- DATA_W, 8, datapath width of A, ACC, immediate operand and data ports (≥2)
- ADDR_W, 4, program address width; program depth = 2^ADDR_W words
- CLK_I  in  1  single clock, rising edge
- RST_N_I  in  1  asynchronous, active-low reset
- RUN_I  in  1  start request, sampled only in IDLE
- PROG_WE_I  in  1  program memory write enable, honoured only in IDLE or HALT
- PROG_ADDR_I  in  ADDR_W  program write address
- PROG_DATA_I  in  4+DATA_W  instruction word {opcode[3:0], imm[DATA_W-1:0]}
- DATA_IN_I  in  DATA_W  input data
- DATA_IN_VALID_I  in  1  input data valid
- DATA_IN_READY_O  out  1  core accepts DATA_IN_I this cycle
- DATA_OUT_O  out  DATA_W  last value output by OUT
- DATA_OUT_VALID_O  out  1  one-cycle pulse, DATA_OUT_O updated
- BUSY_O  out  1  high in FETCH or EXEC
- HALTED_O  out  1  high in HALT
- PC_O  out  ADDR_W  current program counter

## Operation
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE → FETCH when RUN_I=1.
  - FETCH → EXEC always.
  - EXEC → FETCH on completion; → HALT on HLT; stays in EXEC while IN waits.
  - HALT → IDLE when RUN_I=0.
- FETCH: IR ← mem[PC] (registered read).
- EXEC: decode IR. PC ← target for a taken jump, else PC+1, modulo 2^ADDR_W.
- A jump never also increments PC.
- Opcodes:
  - 0 NOP
  - 1 LDI: A←imm
  - 2 ADD: {C,ACC}←ACC+A
  - 3 SUB: {B,ACC}←ACC−A; C=1 on borrow
  - 4 JMP: PC←imm[ADDR_W-1:0]
  - 5 JZ: jump if Z=1
  - 6 JNZ: jump if Z=0
  - 7 OUT: DATA_OUT_O←ACC, pulse valid
  - 8 IN: A←DATA_IN_I on handshake
  - 9 JC: jump if C=1
  - 10 MOVA: ACC←A
  - 15 HLT
  - 11–14: NOP
- Flags:
  - Z is updated by ADD, SUB and MOVA (Z = ACC_next==0).
  - C is updated by ADD and SUB only.
- IN: DATA_IN_READY_O=1 throughout EXEC of IN. The transfer completes in the cycle where VALID && READY; PC advances in that same cycle.
- Entering IDLE from HALT clears PC to 0. A, ACC and flags are retained.
- PROG_WE_I while BUSY_O=1 is ignored; memory is unchanged.
- RUN_I held high after HLT keeps the core in HALT. The program restarts only after RUN_I drops and is reasserted.

## Timing
- Reset (async assert, sync-to-clock deassert internally):
  - State=IDLE; PC, A, ACC, IR, Z, C = 0.
  - DATA_OUT_O=0; all valid/ready/busy/halted outputs = 0.
  - Program memory contents are not reset.
- Every instruction takes 2 cycles (FETCH+EXEC). IN takes 2+N cycles, where N is the number of wait cycles before DATA_IN_VALID_I.
- DATA_OUT_VALID_O asserts in the cycle after OUT's EXEC and lasts exactly 1 cycle.
- Program write takes effect at the clock edge. A write and a RUN_I in the same IDLE cycle are both honoured; the first fetch sees the written data.
- Reset mid-IN or mid-run aborts immediately with no output pulse.
- A jump to its own address loops forever at 2 cycles per iteration.
- Arithmetic wraps at DATA_W. For example, ACC=0xFF + A=0x01 gives ACC=0x00, Z=1, C=1 (DATA_W=8).

## Structure
- Package mcu_pkg holds:
  - opcode localparams OP_NOP … OP_HLT
  - state encoding ST_IDLE/ST_FETCH/ST_EXEC/ST_HALT
  - the opcode-width constant (4)
- Sub-module mcu_prog_mem: a 2^ADDR_W × (4+DATA_W) RAM with synchronous write and registered read, inferable as distributed/block RAM.
- The core contains the FSM, PC, IR, A, ACC, flags and ALU.

## Test plan
- Reset mid-run: assert RST_N_I during EXEC → all outputs 0 on that edge, state IDLE, no DATA_OUT_VALID_O.
- Load LDI 5; ADD; ADD; OUT; HLT and pulse RUN_I → DATA_OUT_O=0x0A with a single valid pulse, HALTED_O=1, PC_O=4.
- Loop: LDI 1; MOVA; LDI 1; SUB; JNZ 3; OUT; HLT → SUB gives 0 and Z=1 on the first pass, so JNZ falls through; OUT=0x00.
- Carry: LDI 0xFF; MOVA; LDI 1; ADD; JC 6; HLT; OUT; HLT → JC is taken, OUT=0x00, halts at PC=7.
- IN handshake: IN; MOVA; OUT; HLT with DATA_IN_VALID_I held low for 5 cycles, then 0x3C → READY held for 6 cycles, transfer occurs on the VALID cycle, OUT=0x3C.
- PROG_WE_I while BUSY_O=1 → memory unchanged, verified by rerunning the program after HALT→IDLE. PC wraps from 15 to 0 on straight-line NOPs (ADDR_W=4).
